ibex_ex_alu_iter_md: RTL and testbench
======================================

# ibex_ex_alu_iter_md

Execution-stage datapath for an RV32IM core: a single-cycle RV32I ALU plus an iterative 32-cycle multiplier/divider, muxed onto one result bus. Sits between the ID stage (operands, operator, enables) and writeback/LSU (result, adder result, branch decision). Shift-add multiplication and restoring division run with data-independent latency.

## Interface
- No parameters.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `alu_operator_i`  in  4  ALU op: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 EQ, 11 NE, 12 LT, 13 LTU, 14 GE, 15 GEU.
- `alu_operand_a_i` / `alu_operand_b_i`  in  32  ALU operands.
- `md_operator_i`  in  2  0 MUL, 1 MULH, 2 DIV, 3 REM.
- `md_signed_mode_i`  in  2  bit0 = operand A signed, bit1 = operand B signed.
- `mult_en_i` / `div_en_i`  in  1  dynamic enables, held high for the whole operation.
- `mult_sel_i` / `div_sel_i`  in  1  static selects for the result mux.
- `md_operand_a_i` / `md_operand_b_i`  in  32  multdiv operands.
- `md_ready_id_i`  in  1  ID accepts the finished result.
- `alu_adder_result_o`  out  32  adder output, used as the LSU address.
- `result_ex_o`  out  32  selected result.
- `branch_decision_o`  out  1  comparison outcome.
- `ex_valid_o`  out  1  result valid this cycle.

## Operation
- `md_sel` = `mult_sel_i | div_sel_i`.
- `result_ex_o` = `md_sel` ? multdiv result : ALU result.
- `ex_valid_o` = `md_sel` ? multdiv valid : 1.
- **Adder:** `a - b` for SUB and ops 8-15; `a + b` otherwise. Result is 32 bits; carry is discarded.
- **Shifts:** shift amount is `b[4:0]`. SRA replicates `a[31]`.
- **Comparisons:**
  - Ops 8-15 produce a 1-bit comparison result `cmp`; `result_o` = `{31'b0, cmp}`.
  - SLT/LT/GE are signed; SLTU/LTU/GEU are unsigned.
  - `branch_decision_o` = `cmp` for ops 8-15, else 0.
- **Multdiv FSM:** IDLE, CALC, FINISH.
  - IDLE → CALC when `mult_en_i | div_en_i`. Latches operand magnitudes, result sign and operator; counter = 0.
  - CALC iterates once per cycle, 32 iterations, then → FINISH.
  - FINISH: multdiv valid = 1; → IDLE when `md_ready_id_i`, else hold with the result stable.
  - Valid is 0 in IDLE and CALC.
- **Abort:** if both enables drop while in CALC or FINISH, go to IDLE next cycle and assert no valid.
- **MUL:** low 32 bits of the product.
- **MULH:** high 32 bits of the 64-bit product.
  - `signed_mode` 11 = MULH, 01 = MULHSU, 00 = MULHU.
  - Computed on magnitudes; the 64-bit product is negated if operand signs differ.
- **DIV/REM:** signed when `signed_mode` = 11, unsigned when 00.
  - Quotient takes the XOR of the operand signs.
  - Remainder takes the dividend's sign.
- **Division by zero:** DIV = 0xFFFFFFFF; REM = dividend.
- **Signed overflow** (0x80000000 / -1): DIV = 0x80000000, REM = 0.
- Both special cases still take the full 32-cycle latency.

## Timing
- ALU path is purely combinational: zero latency.
- Multdiv: enable first sampled high in IDLE at edge N → valid at cycle N+33 (1 latch cycle + 32 CALC cycles).
- Valid persists until `md_ready_id_i` is sampled high; FINISH → IDLE on that edge.
- Next op can start in the following cycle.
- Reset, sampled at a clock edge, forces IDLE, counter = 0, and clears all internal registers.
  - After reset, multdiv valid = 0.
  - `ex_valid_o` = 1 when `md_sel` = 0, 0 when `md_sel` = 1.
- Reset mid-operation discards the operation.
- Changes to `md_operand_*` after the start edge are ignored.

## Configuration
- `IBEX_EX_MULTDIV_EN` defined: multdiv unit is instantiated as above.
- Undefined:
  - No multdiv logic is built and `md_sel` is tied to 0.
  - `result_ex_o` is always the ALU result; `ex_valid_o` is constant 1.
  - Multdiv inputs are unused.

## Test plan
- **ALU op sweep:**
  - SUB 5 - 7 → 0xFFFFFFFE.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLTU 1 vs 0xFFFFFFFF → 1.
  - GE -1 vs 0 → `branch_decision_o` = 0.
- **MULH signed:**
  - 0xFFFFFFFF × 0xFFFFFFFF (mode 11) → 0x00000000.
  - Same with MULHU → 0xFFFFFFFE.
  - Valid exactly 33 cycles after enable.
- **Division by zero:** DIV 7/0 unsigned → 0xFFFFFFFF; REM 7/0 → 7.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- **Signed division:** DIV -7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
- **Handshake and abort:**
  - Hold `md_ready_id_i` = 0 for 5 cycles in FINISH → valid and result stay stable.
  - Drop enables at CALC cycle 10 → IDLE next cycle, no valid.
  - Reset mid-CALC → IDLE.

Source files
------------

// File: rtl/ibex_ex_alu_iter_md.sv
// RV32IM execute stage: single-cycle ALU plus iterative 32-cycle mul/div.
// Define IBEX_EX_MULTDIV_EN to build the multiplier/divider.
module ibex_ex_alu_iter_md (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  alu_operator_i,
  input  logic [31:0] alu_operand_a_i,
  input  logic [31:0] alu_operand_b_i,
  input  logic [1:0]  md_operator_i,
  input  logic [1:0]  md_signed_mode_i,
  input  logic        mult_en_i,
  input  logic        div_en_i,
  input  logic        mult_sel_i,
  input  logic        div_sel_i,
  input  logic [31:0] md_operand_a_i,
  input  logic [31:0] md_operand_b_i,
  input  logic        md_ready_id_i,
  output logic [31:0] alu_adder_result_o,
  output logic [31:0] result_ex_o,
  output logic        branch_decision_o,
  output logic        ex_valid_o
);

  logic        is_sub;
  logic        lt_s;
  logic        lt_u;
  logic        eq;
  logic        cmp;
  logic [4:0]  shamt;
  logic [31:0] sra_res;
  logic [31:0] alu_result;

  assign is_sub = (alu_operator_i == 4'd1) | alu_operator_i[3];
  assign alu_adder_result_o = is_sub ?
    (alu_operand_a_i - alu_operand_b_i) :
    (alu_operand_a_i + alu_operand_b_i);

  assign lt_s = $signed(alu_operand_a_i) < $signed(alu_operand_b_i);
  assign lt_u = alu_operand_a_i < alu_operand_b_i;
  assign eq   = alu_operand_a_i == alu_operand_b_i;

  assign shamt   = alu_operand_b_i[4:0];
  assign sra_res = $unsigned($signed(alu_operand_a_i) >>> shamt);

  always_comb begin
    cmp = 1'b0;
    unique case (alu_operator_i)
      4'd8, 4'd12: cmp = lt_s;
      4'd9, 4'd13: cmp = lt_u;
      4'd10:       cmp = eq;
      4'd11:       cmp = ~eq;
      4'd14:       cmp = ~lt_s;
      4'd15:       cmp = ~lt_u;
      default:     cmp = 1'b0;
    endcase
  end

  always_comb begin
    alu_result = {31'b0, cmp};
    unique case (alu_operator_i)
      4'd0, 4'd1: alu_result = alu_adder_result_o;
      4'd2:       alu_result = alu_operand_a_i ^ alu_operand_b_i;
      4'd3:       alu_result = alu_operand_a_i | alu_operand_b_i;
      4'd4:       alu_result = alu_operand_a_i & alu_operand_b_i;
      4'd5:       alu_result = alu_operand_a_i << shamt;
      4'd6:       alu_result = alu_operand_a_i >> shamt;
      4'd7:       alu_result = sra_res;
      default:    alu_result = {31'b0, cmp};
    endcase
  end

  assign branch_decision_o = alu_operator_i[3] & cmp;

`ifdef IBEX_EX_MULTDIV_EN

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FINISH
  } md_state_e;

  md_state_e   state_q;
  md_state_e   state_d;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] opb_q;
  logic [1:0]  op_q;
  logic        neg_q;
  logic        neg_r_q;
  logic        div_zero_q;

  logic        md_en;
  logic        md_sel;
  logic        md_valid;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_rs;
  logic [32:0] div_diff;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] md_result;

  assign md_en  = mult_en_i | div_en_i;
  assign md_sel = mult_sel_i | div_sel_i;

  assign sign_a = md_signed_mode_i[0] & md_operand_a_i[31];
  assign sign_b = md_signed_mode_i[1] & md_operand_b_i[31];
  assign mag_a  = sign_a ? -md_operand_a_i : md_operand_a_i;
  assign mag_b  = sign_b ? -md_operand_b_i : md_operand_b_i;

  // lo holds the multiplier (shifted out) or the dividend/quotient
  assign mul_sum  = {1'b0, hi_q} + ({33{lo_q[0]}} & {1'b0, opb_q});
  assign div_rs   = {hi_q, lo_q[31]};
  assign div_diff = div_rs - {1'b0, opb_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE:   if (md_en) state_d = MD_CALC;
      MD_CALC: begin
        if (!md_en)              state_d = MD_IDLE;
        else if (cnt_q == 5'd31) state_d = MD_FINISH;
      end
      MD_FINISH: begin
        if (md_ready_id_i || !md_en) state_d = MD_IDLE;
      end
      default:   state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == MD_IDLE && md_en) begin
        cnt_q      <= '0;
        hi_q       <= '0;
        lo_q       <= mag_a;
        opb_q      <= mag_b;
        op_q       <= md_operator_i;
        neg_q      <= sign_a ^ sign_b;
        neg_r_q    <= sign_a;
        div_zero_q <= (md_operand_b_i == 32'd0);
      end else if (state_q == MD_CALC && md_en) begin
        cnt_q <= cnt_q + 5'd1;
        if (op_q[1]) begin
          if (!div_diff[32]) begin
            hi_q <= div_diff[31:0];
            lo_q <= {lo_q[30:0], 1'b1};
          end else begin
            hi_q <= div_rs[31:0];
            lo_q <= {lo_q[30:0], 1'b0};
          end
        end else begin
          {hi_q, lo_q} <= {mul_sum, lo_q[31:1]};
        end
      end
    end
  end

  assign prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo  = neg_q ? -lo_q : lo_q;
  assign rem  = neg_r_q ? -hi_q : hi_q;

  always_comb begin
    md_result = prod[31:0];
    unique case (op_q)
      2'd0: md_result = prod[31:0];
      2'd1: md_result = prod[63:32];
      2'd2: md_result = div_zero_q ? 32'hFFFF_FFFF : quo;
      2'd3: md_result = rem;
      default: md_result = prod[31:0];
    endcase
  end

  assign md_valid    = (state_q == MD_FINISH);
  assign result_ex_o = md_sel ? md_result : alu_result;
  assign ex_valid_o  = md_sel ? md_valid : 1'b1;

`else

  logic unused_md;

  assign unused_md = ^{clk_i, rst_i, md_operator_i,
                       md_signed_mode_i, mult_en_i, div_en_i,
                       mult_sel_i, div_sel_i, md_operand_a_i,
                       md_operand_b_i, md_ready_id_i};

  assign result_ex_o = alu_result;
  assign ex_valid_o  = 1'b1;

`endif

endmodule

// File: tb/tb_ibex_ex_alu_iter_md.sv
// Randomised self-checking bench for ibex_ex_alu_iter_md.
// Multdiv scenarios run only when IBEX_EX_MULTDIV_EN is defined.
module tb_ibex_ex_alu_iter_md;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  alu_operator_i;
  logic [31:0] alu_operand_a_i;
  logic [31:0] alu_operand_b_i;
  logic [1:0]  md_operator_i;
  logic [1:0]  md_signed_mode_i;
  logic        mult_en_i;
  logic        div_en_i;
  logic        mult_sel_i;
  logic        div_sel_i;
  logic [31:0] md_operand_a_i;
  logic [31:0] md_operand_b_i;
  logic        md_ready_id_i;
  logic [31:0] alu_adder_result_o;
  logic [31:0] result_ex_o;
  logic        branch_decision_o;
  logic        ex_valid_o;

  int checks = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  ibex_ex_alu_iter_md dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .alu_operator_i     (alu_operator_i),
    .alu_operand_a_i    (alu_operand_a_i),
    .alu_operand_b_i    (alu_operand_b_i),
    .md_operator_i      (md_operator_i),
    .md_signed_mode_i   (md_signed_mode_i),
    .mult_en_i          (mult_en_i),
    .div_en_i           (div_en_i),
    .mult_sel_i         (mult_sel_i),
    .div_sel_i          (div_sel_i),
    .md_operand_a_i     (md_operand_a_i),
    .md_operand_b_i     (md_operand_b_i),
    .md_ready_id_i      (md_ready_id_i),
    .alu_adder_result_o (alu_adder_result_o),
    .result_ex_o        (result_ex_o),
    .branch_decision_o  (branch_decision_o),
    .ex_valid_o         (ex_valid_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference ALU from the ISA definitions using wide integers.
  task automatic alu_ref(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [31:0] res,
                         output logic [31:0] add,
                         output logic br);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint sum;
    logic c;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sum = (op == 4'd1 || op >= 4'd8) ? ua - ub : ua + ub;
    add = sum[31:0];
    c = 1'b0;
    if (op == 4'd8 || op == 4'd12) c = sa < sb;
    if (op == 4'd9 || op == 4'd13) c = ua < ub;
    if (op == 4'd10) c = ua == ub;
    if (op == 4'd11) c = ua != ub;
    if (op == 4'd14) c = sa >= sb;
    if (op == 4'd15) c = ua >= ub;
    br = (op >= 4'd8) ? c : 1'b0;
    case (op)
      4'd0, 4'd1: res = add;
      4'd2: res = a ^ b;
      4'd3: res = a | b;
      4'd4: res = a & b;
      4'd5: res = 32'(ua * (64'd1 << b[4:0]));
      4'd6: res = 32'(ua / (64'd1 << b[4:0]));
      4'd7: begin
        sum = sa;
        for (int i = 0; i < int'(b[4:0]); i++)
          sum = (sum < 0) ? (sum - 1) / 2 : sum / 2;
        res = sum[31:0];
      end
      default: res = {31'b0, c};
    endcase
  endtask

  function automatic logic [31:0] md_ref(input logic [1:0] op,
                                         input logic [1:0] mode,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint av;
    longint bv;
    longint p;
    av = mode[0] ? longint'($signed(a)) : longint'({32'b0, a});
    bv = mode[1] ? longint'($signed(b)) : longint'({32'b0, b});
    p = av * bv;
    if (op == 2'd0) return p[31:0];
    if (op == 2'd1) return p[63:32];
    if (b == 32'd0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
    p = (op == 2'd2) ? av / bv : av % bv;
    return p[31:0];
  endfunction

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (ex_valid_o !== 1'b1)
      $display("FAIL reset_valid_alu: got %b want 1", ex_valid_o);
    else passed++;
    mult_sel_i = 1'b1;
    #1;
`ifdef IBEX_EX_MULTDIV_EN
    checks++;
    if (ex_valid_o !== 1'b0)
      $display("FAIL reset_valid_md: got %b want 0", ex_valid_o);
    else passed++;
    checks++;
    if (result_ex_o !== 32'd0)
      $display("FAIL reset_result_md: got %h want 0", result_ex_o);
    else passed++;
`else
    checks++;
    if (ex_valid_o !== 1'b1)
      $display("FAIL nomd_valid: got %b want 1", ex_valid_o);
    else passed++;
`endif
    mult_sel_i = 1'b0;
    #1;
  endtask

  task automatic test_alu_directed();
    logic [3:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exp [4];
    ops = '{4'd1, 4'd7, 4'd9, 4'd14};
    as  = '{32'd5, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF};
    bs  = '{32'd7, 32'd4, 32'hFFFF_FFFF, 32'd0};
    exp = '{32'hFFFF_FFFE, 32'hF800_0000, 32'd1, 32'd0};
    for (int i = 0; i < 4; i++) begin
      alu_operator_i  = ops[i];
      alu_operand_a_i = as[i];
      alu_operand_b_i = bs[i];
      #1;
      checks++;
      if (result_ex_o !== exp[i])
        $display("FAIL alu_dir%0d: got %h want %h",
                 i, result_ex_o, exp[i]);
      else passed++;
    end
    checks++;
    if (branch_decision_o !== 1'b0)
      $display("FAIL ge_branch: got %b want 0", branch_decision_o);
    else passed++;
  endtask

  task automatic test_alu_random();
    logic [31:0] er;
    logic [31:0] ea;
    logic        eb;
    int errs;
    for (int i = 0; i < 96; i++) begin
      alu_operator_i  = 4'(i % 16);
      alu_operand_a_i = $urandom;
      alu_operand_b_i = (i % 5 == 0) ? alu_operand_a_i : $urandom;
      if (i % 7 == 0) alu_operand_a_i[31] = ~alu_operand_a_i[31];
      #1;
      alu_ref(alu_operator_i, alu_operand_a_i, alu_operand_b_i,
              er, ea, eb);
      errs = 0;
      if (result_ex_o !== er) errs++;
      if (alu_adder_result_o !== ea) errs++;
      if (branch_decision_o !== eb) errs++;
      checks++;
      if (errs != 0)
        $display("FAIL alu_rnd op%0d a=%h b=%h: got %h/%h/%b want %h/%h/%b",
                 alu_operator_i, alu_operand_a_i, alu_operand_b_i,
                 result_ex_o, alu_adder_result_o, branch_decision_o,
                 er, ea, eb);
      else passed++;
    end
    alu_operator_i = 4'd0;
  endtask

`ifdef IBEX_EX_MULTDIV_EN

  task automatic start_md(input logic [1:0] op, input logic [1:0] mode,
                          input logic [31:0] a, input logic [31:0] b);
    md_operator_i    = op;
    md_signed_mode_i = mode;
    md_operand_a_i   = a;
    md_operand_b_i   = b;
    div_en_i   = op[1];
    div_sel_i  = op[1];
    mult_en_i  = ~op[1];
    mult_sel_i = ~op[1];
    md_ready_id_i = 1'b0;
  endtask

  task automatic stop_md();
    mult_en_i  = 1'b0;
    div_en_i   = 1'b0;
    mult_sel_i = 1'b0;
    div_sel_i  = 1'b0;
    md_ready_id_i = 1'b0;
  endtask

  task automatic run_md(input logic [1:0] op, input logic [1:0] mode,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    start_md(op, mode, a, b);
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        md_operand_a_i = $urandom;
        md_operand_b_i = $urandom;
      end
    end while (ex_valid_o !== 1'b1 && lat < 100);
    res = result_ex_o;
  endtask

  task automatic accept_md();
    md_ready_id_i = 1'b1;
    tick();
    stop_md();
    #1;
  endtask

  task automatic check_op(input string name, input logic [1:0] op,
                          input logic [1:0] mode, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    int lat;
    run_md(op, mode, a, b, res, lat);
    checks++;
    if (res !== exp || lat != 33)
      $display("FAIL %s: got %h lat %0d want %h lat 33",
               name, res, lat, exp);
    else passed++;
    accept_md();
  endtask

  task automatic test_mulh();
    check_op("mulh_ss", 2'd1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'h0000_0000);
    check_op("mulhu", 2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE);
  endtask

  task automatic test_div_special();
    check_op("div_by0", 2'd2, 2'b00, 32'd7, 32'd0, 32'hFFFF_FFFF);
    check_op("rem_by0", 2'd3, 2'b00, 32'd7, 32'd0, 32'd7);
    check_op("div_ovf", 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h8000_0000);
    check_op("rem_ovf", 2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
             32'd0);
    check_op("div_neg", 2'd2, 2'b11, -32'd7, 32'd2, 32'hFFFF_FFFD);
    check_op("rem_neg", 2'd3, 2'b11, -32'd7, 32'd2, 32'hFFFF_FFFF);
    check_op("div_s_by0", 2'd2, 2'b11, -32'd9, 32'd0, 32'hFFFF_FFFF);
    check_op("rem_s_by0", 2'd3, 2'b11, -32'd9, 32'd0, -32'd9);
  endtask

  task automatic test_md_random();
    logic [1:0]  op;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 16; i++) begin
      op = 2'(i % 4);
      mode = op[1] ? ((i % 8 < 4) ? 2'b00 : 2'b11) : 2'($urandom);
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      check_op("md_rnd", op, mode, a, b, md_ref(op, mode, a, b));
    end
  endtask

  task automatic test_hold();
    logic [31:0] res;
    logic [31:0] exp;
    int lat;
    int errs;
    exp = md_ref(2'd0, 2'b11, 32'h1234_5678, 32'hFEDC_BA98);
    run_md(2'd0, 2'b11, 32'h1234_5678, 32'hFEDC_BA98, res, lat);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ex_valid_o !== 1'b1 || result_ex_o !== exp) errs++;
    end
    checks++;
    if (errs != 0 || res !== exp)
      $display("FAIL hold: got %h valid %b errs %0d want %h",
               result_ex_o, ex_valid_o, errs, exp);
    else passed++;
    md_ready_id_i = 1'b1;
    tick();
    md_ready_id_i = 1'b0;
    mult_en_i = 1'b0;
    #1;
    checks++;
    if (ex_valid_o !== 1'b0)
      $display("FAIL after_accept: got %b want 0", ex_valid_o);
    else passed++;
    stop_md();
    #1;
  endtask

  task automatic test_abort();
    int seen;
    start_md(2'd2, 2'b00, 32'd1000, 32'd7);
    tick();
    for (int i = 0; i < 10; i++) tick();
    div_en_i = 1'b0;
    tick();
    checks++;
    if (ex_valid_o !== 1'b0)
      $display("FAIL abort_next: got %b want 0", ex_valid_o);
    else passed++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ex_valid_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0)
      $display("FAIL abort_novalid: got %0d valid cycles want 0", seen);
    else passed++;
    stop_md();
    check_op("post_abort", 2'd3, 2'b00, 32'd1000, 32'd7, 32'd6);
  endtask

  task automatic test_reset_mid();
    int seen;
    start_md(2'd0, 2'b00, 32'd12345, 32'd678);
    tick();
    for (int i = 0; i < 15; i++) tick();
    rst_i = 1'b1;
    mult_en_i = 1'b0;
    tick();
    rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ex_valid_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || result_ex_o !== 32'd0)
      $display("FAIL reset_mid: got %0d valid, res %h want 0, 0",
               seen, result_ex_o);
    else passed++;
    stop_md();
    check_op("post_reset", 2'd0, 2'b00, 32'd12345, 32'd678,
             32'd8369910);
  endtask

`else

  task automatic test_no_md();
    logic [31:0] er;
    logic [31:0] ea;
    logic        eb;
    mult_sel_i = 1'b1;
    div_sel_i  = 1'b1;
    mult_en_i  = 1'b1;
    alu_operator_i  = 4'd2;
    alu_operand_a_i = $urandom;
    alu_operand_b_i = $urandom;
    for (int i = 0; i < 40; i++) tick();
    alu_ref(alu_operator_i, alu_operand_a_i, alu_operand_b_i,
            er, ea, eb);
    checks++;
    if (ex_valid_o !== 1'b1 || result_ex_o !== er)
      $display("FAIL no_md: got %h valid %b want %h valid 1",
               result_ex_o, ex_valid_o, er);
    else passed++;
    mult_sel_i = 1'b0;
    div_sel_i  = 1'b0;
    mult_en_i  = 1'b0;
  endtask

`endif

  initial begin
    rst_i = 1'b1;
    alu_operator_i   = 4'd0;
    alu_operand_a_i  = '0;
    alu_operand_b_i  = '0;
    md_operator_i    = '0;
    md_signed_mode_i = '0;
    mult_en_i  = 1'b0;
    div_en_i   = 1'b0;
    mult_sel_i = 1'b0;
    div_sel_i  = 1'b0;
    md_operand_a_i = '0;
    md_operand_b_i = '0;
    md_ready_id_i  = 1'b0;
    test_reset();
    test_alu_directed();
    test_alu_random();
`ifdef IBEX_EX_MULTDIV_EN
    test_mulh();
    test_div_special();
    test_md_random();
    test_hold();
    test_abort();
    test_reset_mid();
`else
    test_no_md();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
